// File: rtl/ps2_keyboard_fifo.sv
// rtl/ps2_keyboard_fifo.sv - PS/2 keyboard receiver, scancode decoder and character FIFO
// Frames are filtered, decoded through an external keymap ROM and queued for a consumer.
module ps2_keyboard_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int ARROW_ESC      = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ps2_clk,
  input  logic                              ps2_data,
  output logic [9:0]                        keymap_addr,
  input  logic [7:0]                        keymap_data,
  output logic [7:0]                        data,
  output logic                              valid,
  input  logic                              ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill,
  output logic                              frame_error,
  output logic                              overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] FILT_LAST  = CW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FILL_FULL  = FW'(FIFO_DEPTH);
  localparam logic [FW-1:0] FILL_ROOM2 = FW'(FIFO_DEPTH - 2);

  // ---------------- synchronizers and clock filter ----------------
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_s;
  logic          data_s;
  logic          clk_f;
  logic [CW-1:0] flt_cnt;
  logic          fall;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_f   <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s == clk_f) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FILT_LAST) begin
      clk_f   <= clk_s;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + CW'(1);
    end
  end

  assign fall = clk_f && !clk_s && (flt_cnt == FILT_LAST);

  // ---------------- frame receiver ----------------
  // shreg collects start..parity; the stop bit is checked straight from data_s
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic          byte_valid;
  logic [7:0]    rx_byte;
  logic          frame_ok;

  assign frame_ok = !shreg[0] && (^shreg[9:1]) && data_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      to_cnt      <= '0;
      byte_valid  <= 1'b0;
      rx_byte     <= '0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            rx_byte    <= shreg[8:1];
          end else begin
            frame_error <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {data_s, shreg[9:1]};
        end
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TO_LAST) begin
          bit_cnt     <= '0;
          to_cnt      <= '0;
          frame_error <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // ---------------- scancode decoder ----------------
  logic       ext, brk;
  logic       lshift, rshift, lctrl, rctrl, lalt, ralt, caps;
  logic       shift, ctrl, meta;
  logic       lk1, lk2;
  logic       esc1, esc2;
  logic [7:0] esc_char;
  logic [7:0] arrow_char;
  logic       is_arrow;
  logic       room2;

  assign shift = lshift | rshift;
  assign ctrl  = lctrl | rctrl;
  assign meta  = lalt | ralt;
  assign room2 = (fill <= FILL_ROOM2);

  always_comb begin
    arrow_char = 8'h00;
    case (rx_byte)
      8'h75:   arrow_char = 8'h41;
      8'h72:   arrow_char = 8'h42;
      8'h6B:   arrow_char = 8'h44;
      8'h74:   arrow_char = 8'h43;
      default: arrow_char = 8'h00;
    endcase
  end

  assign is_arrow = (ARROW_ESC != 0) && (arrow_char != 8'h00);

  always_ff @(posedge clk) begin
    if (reset) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      lshift      <= 1'b0;
      rshift      <= 1'b0;
      lctrl       <= 1'b0;
      rctrl       <= 1'b0;
      lalt        <= 1'b0;
      ralt        <= 1'b0;
      caps        <= 1'b0;
      keymap_addr <= '0;
      lk1         <= 1'b0;
      lk2         <= 1'b0;
      esc1        <= 1'b0;
      esc2        <= 1'b0;
      esc_char    <= '0;
    end else begin
      lk1  <= 1'b0;
      lk2  <= lk1;
      esc1 <= 1'b0;
      esc2 <= esc1 && room2;
      if (frame_error) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == 8'hE0) begin
          ext <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!ext && rx_byte == 8'h12) begin
            lshift <= !brk;
          end else if (!ext && rx_byte == 8'h59) begin
            rshift <= !brk;
          end else if (rx_byte == 8'h14) begin
            if (ext) rctrl <= !brk;
            else     lctrl <= !brk;
          end else if (rx_byte == 8'h11) begin
            if (ext) ralt <= !brk;
            else     lalt <= !brk;
          end else if (!ext && rx_byte == 8'h58) begin
            if (!brk) caps <= !caps;
          end else if (!brk) begin
            if (ext) begin
              if (is_arrow) begin
                esc1     <= 1'b1;
                esc_char <= arrow_char;
              end
            end else begin
              keymap_addr <= {caps, shift, rx_byte};
              lk1         <= 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- push selection ----------------
  // lk2 lines up with the ROM output; escape pairs reserve two slots up front
  logic       push;
  logic [7:0] push_data;
  logic       esc_drop;
  logic       unused_kd7;

  assign unused_kd7 = keymap_data[7];

  always_comb begin
    push      = 1'b0;
    push_data = 8'h00;
    esc_drop  = 1'b0;
    if (lk2) begin
      push      = (keymap_data != 8'h00);
      push_data = {meta, (ctrl ? 2'b00 : keymap_data[6:5]), keymap_data[4:0]};
    end else if (esc1) begin
      if (room2) begin
        push      = 1'b1;
        push_data = 8'h1B;
      end else begin
        esc_drop = 1'b1;
      end
    end else if (esc2) begin
      push      = 1'b1;
      push_data = esc_char;
    end
  end

  // ---------------- output FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign full    = (fill == FILL_FULL);
  assign valid   = (fill != '0);
  assign do_push = push && !full;
  assign do_pop  = valid && ready;
  assign data    = valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= (push && full) || esc_drop;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// tb/tb_ps2_keyboard_fifo.sv - directed bench for ps2_keyboard_fifo
// Drives PS/2 frames bit-by-bit and models the keymap ROM with one cycle of latency.
module tb_ps2_keyboard_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [9:0] keymap_addr;
  logic [7:0] keymap_data = 8'h00;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [2:0] fill;
  logic       frame_error;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  ps2_keyboard_fifo #(
    .FIFO_DEPTH(4), .FILTER_LEN(4), .TIMEOUT_CYCLES(300), .ARROW_ESC(1)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keymap_addr(keymap_addr), .keymap_data(keymap_data),
    .data(data), .valid(valid), .ready(ready), .fill(fill),
    .frame_error(frame_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [9:0] a);
    case (a)
      10'h01C: rom = 8'h61;
      10'h11C: rom = 8'h41;
      10'h21C: rom = 8'h41;
      10'h021: rom = 8'h63;
      default: rom = 8'h00;
    endcase
  endfunction

  always @(posedge clk) keymap_data <= rom(keymap_addr);

  always @(negedge clk) begin
    if (frame_error) fe_cnt++;
    if (overflow)    ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (7) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (15) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic lat);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      repeat (7) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && lat) begin
        repeat (8) @(posedge clk);
        #1 check("lat_before", valid, 1'b0);
        @(posedge clk);
        #1 check("lat_rise", valid, 1'b1);
        repeat (6) @(negedge clk);
      end else begin
        repeat (15) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, valid, 1'b1);
    check({tag, "_data"}, data, exp);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ready = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_valid", valid, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_fill", fill, 3'd0);
    check("rst_fe", frame_error, 1'b0);
    check("rst_ov", overflow, 1'b0);
    check("rst_addr", keymap_addr, 10'h000);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // plain 'a' with latency measurement
    send_frame(8'h1C, 1'b0, 1'b1);
    check("a_fill", fill, 3'd1);
    pop_expect("a", 8'h61);
    check("a_empty", fill, 3'd0);

    // shifted 'A' then release
    send_frame(8'h12, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0);
    check("shift_fill", fill, 3'd1);
    pop_expect("shift", 8'h41);
    send_frame(8'h1C, 1'b0, 1'b0);
    pop_expect("unshift", 8'h61);

    // ctrl, then ctrl+alt
    send_frame(8'h14, 1'b0, 1'b0);
    send_frame(8'h21, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h21, 1'b0, 1'b0);
    check("ctrl_fill", fill, 3'd2);
    pop_expect("ctrl", 8'h03);
    pop_expect("ctrlalt", 8'h83);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h14, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0);

    // bad parity
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    check("par_fe", fe_cnt - fe0, 1);
    check("par_fill", fill, 3'd0);
    send_frame(8'h1C, 1'b0, 1'b0);
    pop_expect("par_next", 8'h61);

    // caps lock on, 'a' -> 'A', caps off again
    send_frame(8'h58, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    pop_expect("caps", 8'h41);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h58, 1'b0, 1'b0);
    send_frame(8'h58, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    pop_expect("nocaps", 8'h61);

    // arrow up escape pair
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    check("arrow_fill", fill, 3'd2);
    pop_expect("arrow_esc", 8'h1B);
    pop_expect("arrow_a", 8'h41);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    pop_expect("right_esc", 8'h1B);
    pop_expect("right_c", 8'h43);

    // escape pair with only one slot free, then full FIFO
    for (int i = 0; i < 3; i++) send_frame(8'h1C, 1'b0, 1'b0);
    ov0 = ov_cnt;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    check("esc_ov", ov_cnt - ov0, 1);
    check("esc_ov_fill", fill, 3'd3);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("full_fill", fill, 3'd4);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("full_ov", ov_cnt - ov0, 2);
    check("full_fill2", fill, 3'd4);
    for (int i = 0; i < 4; i++) pop_expect("drain", 8'h61);
    check("drain_fill", fill, 3'd0);

    // partial frame then timeout
    fe0 = fe_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (400) @(negedge clk);
    check("to_fe", fe_cnt - fe0, 1);
    check("to_fill", fill, 3'd0);
    send_frame(8'h1C, 1'b0, 1'b0);
    pop_expect("to_next", 8'h61);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_fifo.md
PS2_KEYBOARD_FIFO -- requirements
Module: ps2_keyboard_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, output queue depth in characters (power of 2, >=2).
REQ-002 SHALL have parameter FILTER_LEN, default 8, consecutive equal samples needed to accept a ps2_clk level change.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, clk cycles of no PS/2 clock falling edge before a partial frame is abandoned.
REQ-004 SHALL have parameter ARROW_ESC, default 1; 1 enables VT52 escape sequences for arrow keys.
REQ-005 SHALL use reset reset, synchronous, active-high; clock clk.
REQ-006 clk  input  1  system clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 ps2_clk  input  1  raw PS/2 clock, asynchronous.
REQ-009 ps2_data  input  1  raw PS/2 data, asynchronous.
REQ-010 keymap_addr  output  10  {caps_lock, shift, scancode} address to an external keymap ROM with 1-cycle read latency.
REQ-011 keymap_data  input  8  ROM output, 0 = unmapped.
REQ-012 data  output  8  character at FIFO head.
REQ-013 valid  output  1  FIFO not empty.
REQ-014 ready  input  1  consumer accepts data this cycle.
REQ-015 fill  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
REQ-016 frame_error  output  1  one-cycle pulse on a discarded frame.
REQ-017 overflow  output  1  one-cycle pulse on a dropped character.

Function
REQ-018 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; filtered ps2_clk SHALL change only after FILTER_LEN consecutive equal synchronized samples.
REQ-019 A filtered ps2_clk 1->0 transition SHALL sample synchronized ps2_data; frame = start(0), 8 data bits LSB first, odd parity, stop(1); the 11th sample completes the frame.
REQ-020 Start!=0, parity even, or stop!=1 -> byte discarded, frame_error pulses, E0/F0 prefix flags cleared.
REQ-021 Nonzero bit count and no falling edge for TIMEOUT_CYCLES -> bit count cleared, prefix flags cleared, frame_error pulses.
REQ-022 Byte E0 sets ext flag; F0 sets brk flag; any other byte is a scancode, processed with current flags, after which both flags clear.
REQ-023 Modifiers, make sets / break clears: 12 lshift, 59 rshift, 14 lctrl, E0 14 rctrl, 11 lalt, E0 11 ralt; shift/ctrl/meta = OR of left and right.
REQ-024 Make of 58 SHALL toggle caps_lock; break of 58 ignored.
REQ-025 Breaks of non-modifier keys, and extended makes other than arrows, SHALL produce no output.
REQ-026 Non-extended non-modifier make: keymap_addr={caps_lock,shift,code} presented; next cycle, if keymap_data!=0, push {meta, ctrl?2'b00:keymap_data[6:5], keymap_data[4:0]}; if 0, push nothing.
REQ-027 Latency: with FIFO empty and ready low, valid SHALL rise exactly 3 clk cycles after the cycle the stop bit is sampled.
REQ-028 ARROW_ESC=1: E0 75/72/6B/74 make SHALL push 8'h1B then 'A'/'B'/'D'/'C' on consecutive cycles; pushed only if >=2 entries free at the first push, else both dropped with one overflow pulse. ARROW_ESC=0: arrows ignored.
REQ-029 FIFO: push when fill==FIFO_DEPTH SHALL drop the character and pulse overflow, even if a pop occurs the same cycle.
REQ-030 Pop SHALL occur on valid && ready; simultaneous push and pop with fill<FIFO_DEPTH leaves fill unchanged.
REQ-031 data SHALL show the head entry whenever valid; pointers wrap modulo FIFO_DEPTH.
REQ-032 Bit reception SHALL continue while the decoder or FIFO is busy; no PS/2 bits lost.

Reset
REQ-033 On reset: valid=0, data=0, fill=0, frame_error=0, overflow=0, keymap_addr=0; all modifier, caps_lock, prefix flags, bit count, filter and timeout counters cleared.
REQ-034 Reset mid-frame or mid-escape-sequence SHALL abandon the frame/sequence with no partial output after reset deasserts.

Verification
REQ-035 Frame 1C ('a' make), keymap[{0,0,1C}]=61, ready=0 -> valid high 3 cycles after stop sample, data=61, fill=1.
REQ-036 Frames 12, 1C, F0 1C, F0 12 with keymap[{0,1,1C}]=41 -> exactly one character 41; shift cleared afterwards.
REQ-037 Frames 14, 21 with keymap=63, then 11, 21 -> data 03, then 83 (ctrl still held: meta|ctrl).
REQ-038 Frame with even parity -> frame_error one pulse, fill unchanged; next good frame decodes normally.
REQ-039 FIFO_DEPTH-1 entries queued, E0 75 sent -> 1B/'A' dropped, overflow one pulse, fill=FIFO_DEPTH-1.
REQ-040 Five bits sent then idle for TIMEOUT_CYCLES -> frame_error pulse; subsequent full frame 1C decodes to 61.
